// File: rtl/aes_round_sequencer.sv
// Purpose  : sequences one AES-128 encryption through the combinational ops unit, one op per cycle.
// Latency  : ciphertext and a one-cycle done pulse 50 cycles after start is accepted.
// Backpres.: start is only sampled in IDLE; while busy it is ignored, not queued.
// Ports    : clk/rst_n (async active-low); start, plaintext, key in; busy, done, ciphertext, round_o out;
//            ops_operand1/ops_operand2/ops_select drive the ops unit, ops_result returns its output.
//            Block words: word[0] carries bytes 0..3, MSB = byte 0.
module aes_round_sequencer #(
  parameter int regSize    = 32,
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [vecSize-1:0][regSize-1:0]   plaintext,
  input  logic [vecSize-1:0][regSize-1:0]   key,
  output logic                              busy,
  output logic                              done,
  output logic [vecSize-1:0][regSize-1:0]   ciphertext,
  output logic [3:0]                        round_o,
  output logic [vecSize-1:0][regSize-1:0]   ops_operand1,
  output logic [vecSize-1:0][regSize-1:0]   ops_operand2,
  output logic [2:0]                        ops_select,
  input  logic [vecSize-1:0][regSize-1:0]   ops_result
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARK0   = 3'd1;
  localparam logic [2:0] S_KEYEXP = 3'd2;
  localparam logic [2:0] S_SUB    = 3'd3;
  localparam logic [2:0] S_SHIFT  = 3'd4;
  localparam logic [2:0] S_MIX    = 3'd5;
  localparam logic [2:0] S_ARK    = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_KEYEXP = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_SHIFT  = 3'b011;
  localparam logic [2:0] OP_MIX    = 3'b100;
  localparam logic [2:0] OP_ARK    = 3'b101;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [2:0]                      fsm;
  logic [vecSize-1:0][regSize-1:0] state_q;
  logic [vecSize-1:0][regSize-1:0] rkey_q;
  logic [3:0]                      round_q;

  assign round_o = round_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      state_q    <= '0;
      rkey_q     <= '0;
      round_q    <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start) begin
            state_q <= plaintext;
            rkey_q  <= key;
            round_q <= 4'd0;
            busy    <= 1'b1;
            fsm     <= S_ARK0;
          end
        end
        S_ARK0: begin
          state_q <= ops_result;
          round_q <= 4'd1;
          fsm     <= S_KEYEXP;
        end
        S_KEYEXP: begin
          rkey_q <= ops_result;
          fsm    <= S_SUB;
        end
        S_SUB: begin
          state_q <= ops_result;
          fsm     <= S_SHIFT;
        end
        S_SHIFT: begin
          state_q <= ops_result;
          // The final round has no MixColumns step.
          fsm     <= (round_q < LAST_ROUND) ? S_MIX : S_ARK;
        end
        S_MIX: begin
          state_q <= ops_result;
          fsm     <= S_ARK;
        end
        S_ARK: begin
          state_q <= ops_result;
          if (round_q < LAST_ROUND) begin
            round_q <= round_q + 4'd1;
            fsm     <= S_KEYEXP;
          end else begin
            ciphertext <= ops_result;
            done       <= 1'b1;
            fsm        <= S_FIN;
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          round_q <= 4'd0;
          fsm     <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          round_q <= 4'd0;
          fsm     <= S_IDLE;
        end
      endcase
    end
  end

  // Operand/select decode for the ops unit; its result is captured on the next edge.
  always_comb begin
    ops_select   = OP_NOP;
    ops_operand1 = '0;
    ops_operand2 = '0;
    case (fsm)
      S_ARK0, S_ARK: begin
        ops_select   = OP_ARK;
        ops_operand1 = state_q;
        ops_operand2 = rkey_q;
      end
      S_KEYEXP: begin
        ops_select      = OP_KEYEXP;
        ops_operand1    = rkey_q;
        // Round number selects the Rcon constant inside the ops unit.
        ops_operand2[0] = {{(regSize-4){1'b0}}, round_q};
      end
      S_SUB: begin
        ops_select   = OP_SUB;
        ops_operand1 = state_q;
      end
      S_SHIFT: begin
        ops_select   = OP_SHIFT;
        ops_operand1 = state_q;
      end
      S_MIX: begin
        ops_select   = OP_MIX;
        ops_operand1 = state_q;
      end
      default: begin
        ops_select   = OP_NOP;
        ops_operand1 = '0;
        ops_operand2 = '0;
      end
    endcase
  end

endmodule
